// File: rtl/fir_meter_pkg.sv
// Shared definitions for the FIR response meter: FSM state encoding and
// counter sizing helper.
package fir_meter_pkg;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } meter_state_e;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/minmax_tracker.sv
// Running signed maximum/minimum of a sample stream with clear, load
// (first sample of a window) and update controls.
module minmax_tracker #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  update,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] cur_max,
    output logic [DATA_WIDTH-1:0] cur_min
);

    // Tracker registers: clear has priority over load, load over update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_max <= '0;
            cur_min <= '0;
        end else if (clear) begin
            cur_max <= '0;
            cur_min <= '0;
        end else if (load) begin
            cur_max <= sample;
            cur_min <= sample;
        end else if (update) begin
            if ($signed(sample) > $signed(cur_max)) begin
                cur_max <= sample;
            end else begin
                cur_max <= cur_max;
            end
            if ($signed(sample) < $signed(cur_min)) begin
                cur_min <= sample;
            end else begin
                cur_min <= cur_min;
            end
        end else begin
            cur_max <= cur_max;
            cur_min <= cur_min;
        end
    end

endmodule

// File: rtl/fir_response_meter.sv
// Peak-to-peak meter for a filtered sine: discards settle samples, then
// reports max/min/pk2pk of each fixed window through a valid/ready handshake.
module fir_response_meter
    import fir_meter_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int SETTLE_SAMPLES = 64,
    parameter int WINDOW_SAMPLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_sample_en,
    input  logic                  i_restart,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [DATA_WIDTH:0]   o_pk2pk,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int CNT_MAX = (SETTLE_SAMPLES > WINDOW_SAMPLES) ? SETTLE_SAMPLES : WINDOW_SAMPLES;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    // With no settle period the meter starts straight in MEASURE.
    localparam meter_state_e ENTRY_STATE  = (SETTLE_SAMPLES > 0) ? SETTLE : MEASURE;

    meter_state_e          state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  valid_s;
    logic                  accept_s, clear_s, load_s, update_s, result_s;
    logic [DATA_WIDTH-1:0] cur_max_s, cur_min_s, win_max_s, win_min_s;
    logic [DATA_WIDTH:0]   pk2pk_s;

    minmax_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (clear_s),
        .load    (load_s),
        .update  (update_s),
        .sample  (i_data),
        .cur_max (cur_max_s),
        .cur_min (cur_min_s)
    );

    // Next-state, counter and tracker control decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        valid_s  = o_valid;
        clear_s  = 1'b0;
        load_s   = 1'b0;
        update_s = 1'b0;
        result_s = 1'b0;
        accept_s = i_sample_en && ((state_r == SETTLE) || (state_r == MEASURE));
        if (i_restart) begin
            state_s = ENTRY_STATE;
            cnt_s   = '0;
            clear_s = 1'b1;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                SETTLE: begin
                    if (accept_s) begin
                        if (cnt_r == SETTLE_LAST) begin
                            cnt_s   = '0;
                            clear_s = 1'b1;
                            state_s = MEASURE;
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                MEASURE: begin
                    if (accept_s) begin
                        load_s   = (cnt_r == '0);
                        update_s = (cnt_r != '0);
                        if (cnt_r == WINDOW_LAST) begin
                            cnt_s    = '0;
                            result_s = 1'b1;
                            valid_s  = 1'b1;
                            state_s  = REPORT;
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                REPORT: begin
                    if (o_valid && i_ready) begin
                        valid_s = 1'b0;
                        clear_s = 1'b1;
                        state_s = MEASURE;
                    end else begin
                        valid_s = o_valid;
                    end
                end
                default: begin
                    state_s = ENTRY_STATE;
                    cnt_s   = '0;
                    clear_s = 1'b1;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // The final window sample is folded in here, since the tracker only sees it next edge.
    always_comb begin
        if (load_s) begin
            win_max_s = i_data;
            win_min_s = i_data;
        end else begin
            if ($signed(i_data) > $signed(cur_max_s)) begin
                win_max_s = i_data;
            end else begin
                win_max_s = cur_max_s;
            end
            if ($signed(i_data) < $signed(cur_min_s)) begin
                win_min_s = i_data;
            end else begin
                win_min_s = cur_min_s;
            end
        end
        pk2pk_s = {win_max_s[DATA_WIDTH-1], win_max_s} - {win_min_s[DATA_WIDTH-1], win_min_s};
    end

    // FSM, counter and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ENTRY_STATE;
            cnt_r   <= '0;
            o_valid <= 1'b0;
            o_max   <= '0;
            o_min   <= '0;
            o_pk2pk <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            o_valid <= valid_s;
            if (result_s) begin
                o_max   <= win_max_s;
                o_min   <= win_min_s;
                o_pk2pk <= pk2pk_s;
            end else begin
                o_max   <= o_max;
                o_min   <= o_min;
                o_pk2pk <= o_pk2pk;
            end
        end
    end

endmodule

// File: tb/tb_fir_response_meter.sv
// Directed, table-driven bench for fir_response_meter with default parameters
// (64 settle samples, 256-sample windows).
module tb_fir_response_meter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n, sample_en, restart, ready, valid;
    logic [DW-1:0] data, omax, omin;
    logic [DW:0]   pk;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        int settle;
        int a;
        int b;
        int exp_max;
        int exp_min;
        int exp_pk;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    fir_response_meter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (data),
        .i_sample_en (sample_en),
        .i_restart   (restart),
        .o_max       (omax),
        .o_min       (omin),
        .o_pk2pk     (pk),
        .o_valid     (valid),
        .i_ready     (ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart   = 1'b1;
        sample_en = 1'b0;
        step();
        restart   = 1'b0;
    endtask

    // Presents n accepted samples alternating a/b; with toggle an idle cycle
    // carrying a large garbage value precedes each accepted sample.
    task automatic feed(input int n, input int a, input int b, input bit toggle, output bit early);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                sample_en = 1'b0;
                data      = 16'd30000;
                step();
                if (valid) early = 1'b1;
            end
            sample_en = 1'b1;
            data      = (i % 2 == 0) ? a[15:0] : b[15:0];
            step();
            if (valid && (i != n - 1)) early = 1'b1;
        end
        sample_en = 1'b0;
    endtask

    initial begin
        bit e;
        int bad;

        vecs[0] = '{settle: 1000,   a: 1000,  b: 1000,   exp_max: 1000,  exp_min: 1000,   exp_pk: 0};
        vecs[1] = '{settle: 0,      a: 32767, b: -32768, exp_max: 32767, exp_min: -32768, exp_pk: 65535};
        vecs[2] = '{settle: 20000,  a: -5,    b: -5,     exp_max: -5,    exp_min: -5,     exp_pk: 0};
        vecs[3] = '{settle: -32768, a: -100,  b: 50,     exp_max: 50,    exp_min: -100,   exp_pk: 150};
        vecs[4] = '{settle: 0,      a: -1,    b: -32768, exp_max: -1,    exp_min: -32768, exp_pk: 32767};

        rst_n = 1'b0; sample_en = 1'b0; restart = 1'b0; ready = 1'b1; data = '0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_valid", valid, 0);
        check("reset_max", omax, 0);
        check("reset_min", omin, 0);
        check("reset_pk2pk", pk, 0);

        // Table-driven windows
        for (int v = 0; v < 5; v++) begin
            pulse_restart();
            feed(64, vecs[v].settle, vecs[v].settle, 1'b0, e);
            check("settle_quiet", longint'(e | valid), 0);
            feed(256, vecs[v].a, vecs[v].b, 1'b0, e);
            check("early_valid", e, 0);
            check("valid_latency", valid, 1);
            check("vec_max", $signed(omax), vecs[v].exp_max);
            check("vec_min", $signed(omin), vecs[v].exp_min);
            check("vec_pk2pk", pk, vecs[v].exp_pk);
            step();
            check("valid_pulse", valid, 0);
        end

        // Backpressure: result held 50 cycles, next window exactly 256 samples later
        ready = 1'b0;
        pulse_restart();
        feed(64, 0, 0, 1'b0, e);
        feed(256, 7, -7, 1'b0, e);
        check("bp_valid", valid, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            sample_en = 1'b1;
            data      = 16'(i * 997);
            step();
            if (!(valid === 1'b1 && $signed(omax) == 7 && $signed(omin) == -7 && pk == 17'd14)) bad++;
        end
        check("bp_hold_stable", bad, 0);
        sample_en = 1'b0;
        ready     = 1'b1;
        step();
        check("bp_accept_clears", valid, 0);
        check("bp_max_kept", $signed(omax), 7);
        feed(256, 9, 9, 1'b0, e);
        check("bp_next_early", e, 0);
        check("bp_next_valid", valid, 1);
        check("bp_next_max", $signed(omax), 9);
        step();

        // Restart mid-window drops that window
        pulse_restart();
        feed(64, 0, 0, 1'b0, e);
        feed(100, 3, 3, 1'b0, e);
        pulse_restart();
        feed(64, 0, 0, 1'b0, e);
        feed(255, 4, 4, 1'b0, e);
        check("restart_drop", longint'(e | valid), 0);
        feed(1, 4, 4, 1'b0, e);
        check("restart_next_valid", valid, 1);
        check("restart_next_max", $signed(omax), 4);
        check("restart_next_min", $signed(omin), 4);
        step();

        // Restart coinciding with the last window sample: no result
        pulse_restart();
        feed(64, 0, 0, 1'b0, e);
        feed(255, 5, 5, 1'b0, e);
        restart = 1'b1; sample_en = 1'b1; data = 16'd5;
        step();
        restart = 1'b0; sample_en = 1'b0;
        check("restart_last_no_result", valid, 0);
        check("restart_last_max_kept", $signed(omax), 4);
        feed(64, 0, 0, 1'b0, e);
        feed(256, 6, 6, 1'b0, e);
        check("resettle_early", e, 0);
        check("resettle_valid", valid, 1);
        check("resettle_max", $signed(omax), 6);
        step();

        // Reset while in REPORT
        ready = 1'b0;
        pulse_restart();
        feed(64, 0, 0, 1'b0, e);
        feed(256, 11, -3, 1'b0, e);
        check("rpt_valid", valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        check("rst_rpt_valid", valid, 0);
        check("rst_rpt_max", omax, 0);
        check("rst_rpt_min", omin, 0);
        check("rst_rpt_pk2pk", pk, 0);

        // 50% sample enable: only enabled samples count, idle garbage ignored
        feed(64, 0, 0, 1'b1, e);
        check("toggle_settle_quiet", longint'(e | valid), 0);
        feed(256, 100, -200, 1'b1, e);
        check("toggle_early", e, 0);
        check("toggle_valid", valid, 1);
        check("toggle_max", $signed(omax), 100);
        check("toggle_min", $signed(omin), -200);
        check("toggle_pk2pk", pk, 300);
        step();
        check("toggle_pulse", valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
